// File: rtl/timer_arb_pkg.sv
// Shared types and defaults for the timer arbiter slice.
// Optional abort-on-withdraw behaviour is enabled by defining TIMER_ARB_ABORT_EN.
package timer_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Index width for a requester vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import timer_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!any && req[IDX_W'(pos)]) begin
        any                = 1'b1;
        idx                = IDX_W'(pos);
        grant[IDX_W'(pos)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin scheduler sharing one down-counting programmable_counter between requesters.
// Define TIMER_ARB_ABORT_EN to release the counter when the owner withdraws its request.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] dur,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     cnt_load,
  output logic                     cnt_enable,
  output logic                     cnt_up_down,
  output logic [WIDTH-1:0]         cnt_load_value,
  output logic [WIDTH-1:0]         cnt_max_count,
  input  logic [WIDTH-1:0]         cnt_count,
  input  logic                     cnt_zero
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  state_t             state, next_state;
  logic [IDX_W-1:0]   g_q, g_next, g_inc;
  logic [IDX_W-1:0]   ptr_q, ptr_next;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_any;
  logic [WIDTH-1:0]   dur_next;
  logic [WIDTH-1:0]   dur_arr [NUM_REQ];
  logic               abort;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_dur
    assign dur_arr[i] = dur[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign cnt_up_down   = 1'b0;
  assign cnt_max_count = '1;
  assign g_inc         = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);

`ifdef TIMER_ARB_ABORT_EN
  assign abort = ~req[g_q] && ((state == LOAD) || (state == RUN));
`else
  assign abort = 1'b0;
`endif

  // Next state; cnt_enable is combinational so the counter stops on the cycle zero is seen.
  always_comb begin
    next_state = state;
    g_next     = g_q;
    ptr_next   = ptr_q;
    dur_next   = cnt_load_value;
    cnt_enable = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          g_next     = arb_idx;
          dur_next   = dur_arr[arb_idx];
          next_state = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          next_state = IDLE;
          ptr_next   = g_inc;
        end else begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          next_state = IDLE;
          ptr_next   = g_inc;
        end else if (cnt_zero) begin
          next_state = DONE;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
        ptr_next   = g_inc;
      end
      default: next_state = IDLE;
    endcase
  end

  // State and registered outputs, all derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      g_q            <= '0;
      ptr_q          <= '0;
      grant          <= '0;
      done           <= '0;
      busy           <= 1'b0;
      cnt_load       <= 1'b0;
      cnt_load_value <= '0;
    end else begin
      state          <= next_state;
      g_q            <= g_next;
      ptr_q          <= ptr_next;
      cnt_load_value <= dur_next;
      busy           <= (next_state != IDLE);
      cnt_load       <= (next_state == LOAD);
      grant          <= (next_state == IDLE) ? '0 : ((state == IDLE) ? arb_grant : grant);
      done           <= (next_state == DONE) ? grant : '0;
    end
  end

  a_count_bounded: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> (cnt_count <= cnt_load_value));

endmodule

// File: tb/tb_timer_arbiter.sv
// Randomized scoreboard bench for timer_arbiter with a behavioural down-counter.
module tb_timer_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned IW = 2;

  typedef logic [IW-1:0] idx_t;
  typedef struct {
    idx_t idx;
    int   cyc;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [W-1:0]   dur_a [N];
  logic [N*W-1:0] dur;
  logic [N-1:0]   grant, done;
  logic           busy, cnt_load, cnt_enable, cnt_up_down, cnt_zero;
  logic [W-1:0]   cnt_load_value, cnt_max_count, cnt_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 0;

  // Reference model state
  int   cyc    = 0;
  bit   m_busy = 0;
  idx_t m_owner = '0;
  idx_t m_ptr   = '0;
  int   m_load = 0;
  int   m_dur  = 0;
  int   m_done = 0;
  exp_t sb[$];

  assign dur = {dur_a[3], dur_a[2], dur_a[1], dur_a[0]};

  timer_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .dur            (dur),
    .grant          (grant),
    .done           (done),
    .busy           (busy),
    .cnt_load       (cnt_load),
    .cnt_enable     (cnt_enable),
    .cnt_up_down    (cnt_up_down),
    .cnt_load_value (cnt_load_value),
    .cnt_max_count  (cnt_max_count),
    .cnt_count      (cnt_count),
    .cnt_zero       (cnt_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural programmable counter
  always @(posedge clk) begin
    if (rst)             cnt_count <= '0;
    else if (cnt_load)   cnt_count <= cnt_load_value;
    else if (cnt_enable) cnt_count <= cnt_up_down ?
                                      ((cnt_count == cnt_max_count) ? '0 : cnt_count + W'(1)) :
                                      cnt_count - W'(1);
  end
  assign cnt_zero = (cnt_count == '0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic idx_t onehot_idx(input logic [N-1:0] v);
    idx_t r = '0;
    for (int i = 0; i < N; i++) if (v[IW'(i)]) r = IW'(i);
    return r;
  endfunction

  // Transaction-level model: interval of D cycles sampled at t completes at t+3+D.
  always @(posedge clk) begin
    bit found;
    found = 0;
    if (rst) begin
      m_busy = 0;
      m_ptr  = '0;
      sb.delete();
    end else if (!m_busy) begin
      if (req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req[m_ptr + IW'(k)]) begin
            found   = 1;
            m_owner = m_ptr + IW'(k);
          end
        end
        m_dur  = 32'(dur_a[m_owner]);
        m_busy = 1;
        m_load = cyc + 1;
        m_done = cyc + 3 + m_dur;
        sb.push_back('{m_owner, m_done});
      end
    end else if (cyc == m_done) begin
      m_busy = 0;
      m_ptr  = m_owner + IW'(1);
    end
`ifdef TIMER_ARB_ABORT_EN
    else if (cyc >= m_load && cyc <= m_load + 1 + m_dur && !req[m_owner]) begin
      m_busy = 0;
      m_ptr  = m_owner + IW'(1);
      void'(sb.pop_back());
    end
`endif
    cyc = cyc + 1;
  end

  // Monitor: compares DUT outputs against the model every cycle, popping expected dones.
  always @(negedge clk) begin
    logic [N-1:0] eg, ed;
    logic         el, ee;
    exp_t         e;
    if (chk_en) begin
      eg = m_busy ? (N'(1) << m_owner) : '0;
      el = m_busy && (cyc == m_load);
      ee = m_busy && (cyc >= m_load + 1) && (cyc <= m_load + m_dur);
`ifdef TIMER_ARB_ABORT_EN
      ee = ee && req[m_owner];
`endif
      ed = '0;
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e  = sb.pop_front();
        ed = N'(1) << e.idx;
      end
      check("grant",      32'(grant),      32'(eg));
      check("busy",       32'(busy),       32'(m_busy));
      check("cnt_load",   32'(cnt_load),   32'(el));
      check("cnt_enable", 32'(cnt_enable), 32'(ee));
      check("done",       32'(done),       32'(ed));
      if (el) check("cnt_load_value", 32'(cnt_load_value), 32'(m_dur));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (!busy && !m_busy) ok = 1;
    end
    check("idle_timeout", 32'(ok), 32'(1));
  endtask

  task automatic serve(input idx_t i, input logic [W-1:0] d);
    bit ok = 0;
    dur_a[i] = d;
    req[i]   = 1'b1;
    for (int c = 0; c < 60 && !ok; c++) begin
      tick();
      if (done[i]) ok = 1;
    end
    req[i] = 1'b0;
    check("serve_timeout", 32'(ok), 32'(1));
    wait_idle();
  endtask

  initial begin
    idx_t order[$];
    idx_t prev;
    bit   hit;
    int   ndone;

    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) dur_a[i] = '0;
    repeat (3) tick();
    chk_en = 1;
    check("rst_load_value", 32'(cnt_load_value), 32'(0));
    check("rst_up_down",    32'(cnt_up_down),    32'(0));
    check("rst_max_count",  32'(cnt_max_count),  32'(8'hFF));
    rst = 1'b0;

    // Contention straight after reset: RR pointer at 0
    for (int i = 0; i < N; i++) dur_a[i] = 8'd2;
    req = '1;
    for (int c = 0; c < 100 && order.size() < 4; c++) begin
      tick();
      if (done != '0) begin
        order.push_back(onehot_idx(done));
        req = req & ~done;
      end
    end
    check("contention_count", 32'(order.size()), 32'(4));
    for (int i = 0; i < 4 && i < order.size(); i++) check("contention_order", 32'(order[i]), 32'(i));
    wait_idle();

    serve(2'd0, 8'd5);
    serve(2'd2, 8'd0);

    // Fairness: two requesters held high must alternate
    order.delete();
    req = 4'b1010;
    for (int c = 0; c < 200 && order.size() < 6; c++) begin
      tick();
      if (done != '0) order.push_back(onehot_idx(done));
    end
    req = '0;
    check("fair_count", 32'(order.size()), 32'(6));
    for (int i = 1; i < order.size(); i++) begin
      prev = order[i-1];
      check("fair_alternate", 32'(order[i]), (prev == 2'd1) ? 32'd3 : 32'd1);
    end
    wait_idle();

    // Synchronous reset mid-RUN at count 3
    dur_a[1] = 8'd6;
    req[1]   = 1'b1;
    hit      = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      tick();
      if (grant[1] && !cnt_load && cnt_count == 8'd3) hit = 1;
    end
    check("reset_reach_count3", 32'(hit), 32'(1));
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    check("midrst_grant",  32'(grant),      32'(0));
    check("midrst_busy",   32'(busy),       32'(0));
    check("midrst_enable", 32'(cnt_enable), 32'(0));
    repeat (10) tick();

    // Owner withdraws in RUN at count 4
    dur_a[0] = 8'd7;
    req[0]   = 1'b1;
    hit      = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      tick();
      if (grant[0] && !cnt_load && cnt_count == 8'd4) hit = 1;
    end
    check("abort_reach_count4", 32'(hit), 32'(1));
    req[0] = 1'b0;
    ndone  = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (done[0]) ndone++;
    end
`ifdef TIMER_ARB_ABORT_EN
    check("abort_done_count", 32'(ndone), 32'(0));
`else
    check("abort_done_count", 32'(ndone), 32'(1));
`endif
    wait_idle();

    // Randomized requester agents
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req[IW'(i)]) begin
          if (done[IW'(i)]) begin
            if ($urandom_range(0, 1) == 0) req[IW'(i)] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) begin
            req[IW'(i)] = 1'b0;
          end
        end else if ($urandom_range(0, 5) == 0) begin
          req[IW'(i)] = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) dur_a[i] = W'($urandom_range(0, 10));
      end
    end
    req = '0;
    wait_idle();
    repeat (3) tick();
    check("scoreboard_drain", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
